// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, class, state and control-word definitions
package cpu_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_SHR  = 5'b00101;
    localparam opcode_t OP_SHRA = 5'b00110;
    localparam opcode_t OP_SHL  = 5'b00111;
    localparam opcode_t OP_ROR  = 5'b01000;
    localparam opcode_t OP_ROL  = 5'b01001;
    localparam opcode_t OP_AND  = 5'b01010;
    localparam opcode_t OP_OR   = 5'b01011;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_ANDI = 5'b01101;
    localparam opcode_t OP_ORI  = 5'b01110;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;

    // Instruction classes: register-register, immediate, mul/div, unary.
    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_MD      = 3'd3,
        CLS_U       = 3'd4
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPA  = 3'd1,
        ST_OPB  = 3'd2,
        ST_WLO  = 3'd3,
        ST_WHI  = 3'd4
    } seq_state_e;

    // Everything the sequencer registers toward the datapath, in one word.
    typedef struct packed {
        logic          busy;
        logic          done;
        logic          err;
        opcode_t       alu_opcode;
        logic [3:0]    reg_sel;
        logic          r_out;
        logic          r_in;
        logic          c_out;
        logic          y_in;
        logic          z_in;
        logic          z_low_out;
        logic          z_high_out;
        logic          lo_in;
        logic          hi_in;
    } seq_ctrl_t;

    function automatic logic [31:0] sext_c(input logic [18:0] c);
        return {{13{c[18]}}, c};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request and datapath-control bundle of the sequencer
interface alu_op_sequencer_if;

    logic        start;
    logic [31:0] ir;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  alu_opcode;
    logic [3:0]  reg_sel;
    logic        r_out;
    logic        r_in;
    logic        c_out;
    logic [31:0] c_sext;
    logic        y_in;
    logic        z_in;
    logic        z_low_out;
    logic        z_high_out;
    logic        lo_in;
    logic        hi_in;

    // Requester side: issues instructions, observes the control strobes.
    modport master (
        output start, ir,
        input  busy, done, err, alu_opcode, reg_sel, r_out, r_in, c_out,
               c_sext, y_in, z_in, z_low_out, z_high_out, lo_in, hi_in
    );

    // Sequencer side.
    modport slave (
        input  start, ir,
        output busy, done, err, alu_opcode, reg_sel, r_out, r_in, c_out,
               c_sext, y_in, z_in, z_low_out, z_high_out, lo_in, hi_in
    );

endinterface

// File: rtl/alu_op_classify.sv
// rtl/alu_op_classify.sv - opcode to instruction-class decode
import cpu_pkg::*;

module alu_op_classify (
    input  opcode_t   opcode,
    output op_class_e op_class
);

    // Anything not listed is rejected as illegal.
    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  op_class = CLS_R;
            OP_ADDI, OP_ANDI, OP_ORI:       op_class = CLS_I;
            OP_MUL, OP_DIV:                 op_class = CLS_MD;
            OP_NEG, OP_NOT:                 op_class = CLS_U;
            default:                        op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle ALU operation sequencer
import cpu_pkg::*;

module alu_op_sequencer (
    input  logic               clock,
    input  logic               clear,
    alu_op_sequencer_if.slave  bus
);

    seq_state_e  state_q;
    seq_state_e  state_d;
    logic [31:0] ir_q;
    logic [31:0] ir_d;
    seq_ctrl_t   ctrl_q;
    seq_ctrl_t   ctrl_d;
    opcode_t     class_opcode;
    op_class_e   op_class;
    logic [3:0]  ra_d;
    logic [3:0]  rb_d;
    logic [3:0]  rc_d;

    // In IDLE the branch decision must be made on the instruction being
    // latched this edge; once busy only the latched copy is consulted.
    assign class_opcode = (state_q == ST_IDLE) ? bus.ir[31:27] : ir_q[31:27];

    alu_op_classify u_classify (
        .opcode   (class_opcode),
        .op_class (op_class)
    );

    // Register fields of the instruction that will be held next cycle.
    assign ra_d = ir_d[26:23];
    assign rb_d = ir_d[22:19];
    assign rc_d = ir_d[18:15];

    // Next state, next latched instruction and the control word for the next state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ctrl_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ir_d = bus.ir;
                    case (op_class)
                        CLS_R, CLS_I, CLS_MD: state_d = ST_OPA;
                        CLS_U:                state_d = ST_OPB;
                        default:              ctrl_d.err = 1'b1;
                    endcase
                end
            end
            ST_OPA:  state_d = ST_OPB;
            ST_OPB:  state_d = ST_WLO;
            ST_WLO:  state_d = (op_class == CLS_MD) ? ST_WHI : ST_IDLE;
            ST_WHI:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the state being entered so that they
        // come straight out of flops aligned with that state.
        if (state_d != ST_IDLE) begin
            ctrl_d.busy       = 1'b1;
            ctrl_d.alu_opcode = ir_d[31:27];
        end

        case (state_d)
            ST_OPA: begin
                ctrl_d.reg_sel = (op_class == CLS_MD) ? ra_d : rb_d;
                ctrl_d.r_out   = 1'b1;
                ctrl_d.y_in    = 1'b1;
            end
            ST_OPB: begin
                ctrl_d.z_in = 1'b1;
                case (op_class)
                    CLS_R: begin
                        ctrl_d.reg_sel = rc_d;
                        ctrl_d.r_out   = 1'b1;
                    end
                    CLS_I: ctrl_d.c_out = 1'b1;
                    default: begin
                        ctrl_d.reg_sel = rb_d;
                        ctrl_d.r_out   = 1'b1;
                    end
                endcase
            end
            ST_WLO: begin
                ctrl_d.z_low_out = 1'b1;
                if (op_class == CLS_MD) begin
                    ctrl_d.lo_in = 1'b1;
                end else begin
                    ctrl_d.reg_sel = ra_d;
                    ctrl_d.r_in    = 1'b1;
                    ctrl_d.done    = 1'b1;
                end
            end
            ST_WHI: begin
                ctrl_d.z_high_out = 1'b1;
                ctrl_d.hi_in      = 1'b1;
                ctrl_d.done       = 1'b1;
            end
            default: ;
        endcase
    end

    // State, instruction latch and output flops; clear kills any write in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.busy       = ctrl_q.busy;
    assign bus.done       = ctrl_q.done;
    assign bus.err        = ctrl_q.err;
    assign bus.alu_opcode = ctrl_q.alu_opcode;
    assign bus.reg_sel    = ctrl_q.reg_sel;
    assign bus.r_out      = ctrl_q.r_out;
    assign bus.r_in       = ctrl_q.r_in;
    assign bus.c_out      = ctrl_q.c_out;
    assign bus.y_in       = ctrl_q.y_in;
    assign bus.z_in       = ctrl_q.z_in;
    assign bus.z_low_out  = ctrl_q.z_low_out;
    assign bus.z_high_out = ctrl_q.z_high_out;
    assign bus.lo_in      = ctrl_q.lo_in;
    assign bus.hi_in      = ctrl_q.hi_in;
    assign bus.c_sext     = sext_c(ir_q[18:0]);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       err;
        logic [4:0] op;
        logic [3:0] sel;
        logic       r_out;
        logic       r_in;
        logic       c_out;
        logic       y_in;
        logic       z_in;
        logic       zlo;
        logic       zhi;
        logic       lo_in;
        logic       hi_in;
    } vec_t;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.busy  = bus.busy;       v.done  = bus.done;      v.err   = bus.err;
        v.op    = bus.alu_opcode; v.sel   = bus.reg_sel;   v.r_out = bus.r_out;
        v.r_in  = bus.r_in;       v.c_out = bus.c_out;     v.y_in  = bus.y_in;
        v.z_in  = bus.z_in;       v.zlo   = bus.z_low_out; v.zhi   = bus.z_high_out;
        v.lo_in = bus.lo_in;      v.hi_in = bus.hi_in;
        return v;
    endfunction

    // Expected per-cycle control words, one entry per cycle after acceptance.
    task automatic push_seq(input logic [31:0] instr, input bit with_idle);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        int cls;
        vec_t v;
        op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
        if (op >= 5'd3 && op <= 5'd11)       cls = 1;
        else if (op >= 5'd12 && op <= 5'd14) cls = 2;
        else if (op == 5'd15 || op == 5'd16) cls = 3;
        else if (op == 5'd17 || op == 5'd18) cls = 4;
        else                                 cls = 0;
        if (cls == 0) begin
            v = '0; v.err = 1'b1; sb.push_back(v);
        end else begin
            if (cls != 4) begin
                v = '0; v.busy = 1'b1; v.op = op; v.sel = (cls == 3) ? ra : rb;
                v.r_out = 1'b1; v.y_in = 1'b1; sb.push_back(v);
            end
            v = '0; v.busy = 1'b1; v.op = op; v.z_in = 1'b1;
            if (cls == 1)      begin v.sel = rc; v.r_out = 1'b1; end
            else if (cls == 2) v.c_out = 1'b1;
            else               begin v.sel = rb; v.r_out = 1'b1; end
            sb.push_back(v);
            v = '0; v.busy = 1'b1; v.op = op; v.zlo = 1'b1;
            if (cls == 3) v.lo_in = 1'b1;
            else begin v.sel = ra; v.r_in = 1'b1; v.done = 1'b1; end
            sb.push_back(v);
            if (cls == 3) begin
                v = '0; v.busy = 1'b1; v.op = op; v.zhi = 1'b1;
                v.hi_in = 1'b1; v.done = 1'b1; sb.push_back(v);
            end
        end
        if (with_idle) sb.push_back('0);
    endtask

    // One-cycle start pulse; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [31:0] instr);
        @(negedge clock);
        bus.ir = instr; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        vec_t o;
        bus.start = 1'b0; bus.ir = 32'h1234_5678;
        #2 clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        o = sample();
        total++;
        if (o !== vec_t'(0)) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
        total++;
        if (bus.c_sext !== 32'h0) begin bad++; $display("FAIL reset_c_sext got=%h want=0", bus.c_sext); end
        @(negedge clock) clear = 1'b1;
    endtask

    task automatic test_add();
        vec_t o, e;
        int k, nbusy;
        logic [31:0] instr;
        instr = mk(5'b00011, 4'd1, 4'd2, {4'd3, 15'h0});
        total++;
        if (instr !== 32'h1891_8000) begin bad++; $display("FAIL add_encoding got=%h want=18918000", instr); end
        push_seq(instr, 1'b1);
        issue(instr);
        k = 0; nbusy = 0;
        while (sb.size() > 0) begin
            if (k > 0) begin @(posedge clock); #1; end
            bus.ir = $urandom();
            e = sb.pop_front(); o = sample(); total++;
            if (o.busy) nbusy++;
            if (o !== e) begin bad++; $display("FAIL add cyc%0d got=%h want=%h", k, o, e); end
            k++;
        end
        total++;
        if (nbusy != 3) begin bad++; $display("FAIL add_busy_cycles got=%0d want=3", nbusy); end
    endtask

    task automatic test_imm(input logic [31:0] instr, input logic [31:0] want_sext);
        vec_t o, e;
        int k;
        push_seq(instr, 1'b1);
        issue(instr);
        k = 0;
        while (sb.size() > 0) begin
            if (k > 0) begin @(posedge clock); #1; end
            bus.ir = $urandom();
            e = sb.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL imm cyc%0d got=%h want=%h", k, o, e); end
            if (k == 1) begin
                total++;
                if (bus.c_sext !== want_sext)
                    begin bad++; $display("FAIL imm_c_sext got=%h want=%h", bus.c_sext, want_sext); end
            end
            k++;
        end
    endtask

    task automatic test_mul();
        vec_t o, e;
        int k, ndone, done_at;
        logic [31:0] instr;
        instr = mk(5'b01111, 4'd6, 4'd7, 19'h0);
        push_seq(instr, 1'b1);
        issue(instr);
        k = 0; ndone = 0; done_at = -1;
        while (sb.size() > 0) begin
            if (k > 0) begin @(posedge clock); #1; end
            e = sb.pop_front(); o = sample(); total++;
            if (o.done) begin ndone++; done_at = k; end
            if (o !== e) begin bad++; $display("FAIL mul cyc%0d got=%h want=%h", k, o, e); end
            k++;
        end
        total++;
        if (ndone != 1 || done_at != 3)
            begin bad++; $display("FAIL mul_done count=%0d at=%0d want count=1 at=3", ndone, done_at); end
    endtask

    task automatic test_neg();
        vec_t o, e;
        int k;
        logic [31:0] instr;
        instr = mk(5'b10001, 4'd2, 4'd9, 19'h0);
        push_seq(instr, 1'b1);
        issue(instr);
        k = 0;
        while (sb.size() > 0) begin
            if (k > 0) begin @(posedge clock); #1; end
            bus.ir = $urandom();
            e = sb.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL neg cyc%0d got=%h want=%h", k, o, e); end
            k++;
        end
    endtask

    task automatic test_illegal_and_held();
        vec_t o, e;
        int k, ndone;
        logic [31:0] instr;
        instr = mk(5'b10011, 4'd5, 4'd5, 19'h1_2345);
        push_seq(instr, 1'b1);
        issue(instr);
        k = 0;
        while (sb.size() > 0) begin
            if (k > 0) begin @(posedge clock); #1; end
            e = sb.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL illegal cyc%0d got=%h want=%h", k, o, e); end
            k++;
        end
        // start stays high over every busy edge; only the IDLE edge may accept.
        instr = mk(5'b01111, 4'd6, 4'd7, 19'h0);
        push_seq(instr, 1'b1);
        @(negedge clock);
        bus.ir = instr; bus.start = 1'b1;
        @(posedge clock); #1;
        k = 0; ndone = 0;
        while (sb.size() > 0) begin
            if (k > 0) begin @(posedge clock); #1; end
            e = sb.pop_front(); o = sample(); total++;
            if (o.done) ndone++;
            if (o !== e) begin bad++; $display("FAIL held_mul cyc%0d got=%h want=%h", k, o, e); end
            if (k == 4) bus.start = 1'b0;
            k++;
        end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL held_mul_done got=%0d want=1", ndone); end
    endtask

    task automatic test_back_to_back();
        vec_t o, e;
        int k;
        logic [31:0] instr;
        instr = mk(5'b01010, 4'd10, 4'd11, {4'd12, 15'h0});
        push_seq(instr, 1'b1);
        push_seq(instr, 1'b1);
        @(negedge clock);
        bus.ir = instr; bus.start = 1'b1;
        @(posedge clock); #1;
        k = 0;
        while (sb.size() > 0) begin
            if (k > 0) begin @(posedge clock); #1; end
            e = sb.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL b2b cyc%0d got=%h want=%h", k, o, e); end
            if (k == 4) bus.start = 1'b0;
            k++;
        end
    endtask

    task automatic test_clear_mid();
        vec_t o, e;
        int k;
        logic hi_seen;
        logic [31:0] instr;
        instr = mk(5'b01111, 4'd6, 4'd7, 19'h4_0000);
        push_seq(instr, 1'b0);
        issue(instr);
        for (k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            e = sb.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL clr_pre cyc%0d got=%h want=%h", k, o, e); end
        end
        sb.delete();
        #2 clear = 1'b0;
        #1;
        o = sample(); total++;
        if (o !== vec_t'(0)) begin bad++; $display("FAIL clr_async got=%h want=0", o); end
        total++;
        if (bus.c_sext !== 32'h0) begin bad++; $display("FAIL clr_c_sext got=%h want=0", bus.c_sext); end
        hi_seen = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            if (bus.hi_in || bus.busy) hi_seen = 1'b1;
        end
        @(negedge clock) clear = 1'b1;
        repeat (2) begin
            @(posedge clock); #1;
            if (bus.hi_in || bus.busy) hi_seen = 1'b1;
        end
        total++;
        if (hi_seen !== 1'b0) begin bad++; $display("FAIL clr_no_resume got=%b want=0", hi_seen); end
        instr = mk(5'b00011, 4'd1, 4'd2, {4'd3, 15'h0});
        push_seq(instr, 1'b1);
        issue(instr);
        k = 0;
        while (sb.size() > 0) begin
            if (k > 0) begin @(posedge clock); #1; end
            e = sb.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL clr_post cyc%0d got=%h want=%h", k, o, e); end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm(mk(5'b01100, 4'd4, 4'd5, 19'h7_FFFF), 32'hFFFF_FFFF);
        test_imm(mk(5'b01101, 4'd3, 4'd8, 19'h3_FFFF), 32'h0003_FFFF);
        test_mul();
        test_neg();
        test_illegal_and_held();
        test_back_to_back();
        test_clear_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have ports:
 - clock  in  1  sole clock; all state on the rising edge.
 - clear  in  1  reset, asynchronous, active-low.
 - start  in  1  request to execute the instruction on ir.
 - ir  in  32  instruction: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15], C[18:0].
 - busy  out  1  sequence in progress.
 - done  out  1  one-cycle pulse on the final write cycle.
 - err  out  1  one-cycle pulse when an unsupported opcode is rejected.
 - alu_opcode  out  5  opcode presented to the ALU.
 - reg_sel  out  4  register-file index for r_out/r_in.
 - r_out  out  1  selected register drives the bus.
 - r_in  out  1  selected register loads from the bus.
 - c_out  out  1  sign-extended C drives the bus.
 - c_sext  out  32  C[18:0] sign-extended to 32 bits.
 - y_in, z_in, z_low_out, z_high_out, lo_in, hi_in  out  1 each  datapath strobes.
REQ-002 Opcode constants SHALL be: add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010.

Function
REQ-003 States SHALL be IDLE, OPA, OPB, WLO, WHI; busy=1 in every state except IDLE.
REQ-004 In IDLE with start=1, ir SHALL be latched; all outputs thereafter use only the latched copy.
REQ-005 start SHALL be ignored outside IDLE; ir changes while busy SHALL have no effect.
REQ-006 Class R (00011-01011) and class I (01100-01110): IDLE->OPA->OPB->WLO->IDLE.
REQ-007 Class MD (01111, 10000): IDLE->OPA->OPB->WLO->WHI->IDLE.
REQ-008 Class U (10001, 10010): IDLE->OPB->WLO->IDLE (OPA skipped).
REQ-009 Any other opcode: err=1 for one cycle in the cycle following acceptance, state stays IDLE, no strobe asserted.
REQ-010 OPA: reg_sel=Rb (R, I) or Ra (MD); r_out=1, y_in=1.
REQ-011 OPB: z_in=1; R: reg_sel=Rc, r_out=1; I: c_out=1; MD and U: reg_sel=Rb, r_out=1.
REQ-012 WLO: z_low_out=1; MD: lo_in=1; others: reg_sel=Ra, r_in=1; done=1 unless MD.
REQ-013 WHI: z_high_out=1, hi_in=1, done=1.
REQ-014 alu_opcode SHALL equal the latched opcode while busy, 00000 in IDLE.
REQ-015 c_sext SHALL be {13 copies of C[18], C[18:0]} of the latched ir, combinational.
REQ-016 All strobes SHALL be registered (Moore), at most one of r_out/c_out/z_low_out/z_high_out high per cycle.
REQ-017 Latency start-to-done: 3 cycles (R, I), 4 (MD), 2 (U); start asserted in the done cycle SHALL be ignored; it is accepted in the following IDLE cycle.
REQ-018 reg_sel SHALL be 0 whenever r_out and r_in are both 0.

Reset
REQ-019 clear=0 SHALL immediately force IDLE, latched ir=0, every output 0, including mid-sequence; no partial write strobe may survive.
REQ-020 After clear deasserts, the first accepted start SHALL begin a clean sequence.

Structure
REQ-021 Opcode constants, class encodings and state encoding SHALL live in shared package cpu_pkg, reused by the ALU and control unit.
REQ-022 Opcode-to-class decode SHALL be a sub-module alu_op_classify (opcode in; class R/I/MD/U/illegal out).

Verification
REQ-023 add R1,R2,R3 (ir=0x18918000), start 1 cycle -> OPA reg_sel=2 y_in; OPB reg_sel=3 z_in alu_opcode=00011; WLO reg_sel=1 r_in done; busy 3 cycles.
REQ-024 addi R4,R5,-1 (C=0x7FFFF) -> OPB c_out=1, c_sext=0xFFFFFFFF; WLO reg_sel=4 r_in.
REQ-025 mul R6,R7 (opcode 01111) -> OPA reg_sel=6; OPB reg_sel=7; WLO lo_in; WHI hi_in done; done exactly once, 4 cycles after start.
REQ-026 neg R2,R9 -> OPB first busy cycle reg_sel=9 z_in alu_opcode=10001; WLO reg_sel=2 r_in done.
REQ-027 Opcode 10011 -> err pulse, busy=0, no strobes; then start held high across a mul -> exactly one sequence, re-accepted only after return to IDLE.
REQ-028 clear low during WLO of mul -> all outputs 0 asynchronously, no hi_in ever; post-reset add completes normally.
